// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default
// widths and the wait-counter width.
package dmem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int WCNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data memory, 2^ADDR_W x DATA_W.
// dout is registered and read-first; contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // One access port: optional write, registered read of the same address.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: latches the address strobe into a MAR, accepts a
// single read or write from IDLE, optionally inserts wait states, performs
// the array access and pulses ready in DONE.
// Optional feature: define DMEM_WAIT_EN to insert WAIT_CYCLES wait states
// per access; without it the FSM goes straight from IDLE to ACCESS.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_mar,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_oe,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_CYCLES);

    dmem_state_e       state, state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem_dout;
    logic              op_rd;
    logic              err_q;
    logic              accept;
    logic              illegal;

    // A request is taken only from IDLE with exactly one of rd/wr set.
    assign accept  = (state == ST_IDLE) && (rd ^ wr);
    assign illegal = (state == ST_IDLE) && rd && wr;

`ifdef DMEM_WAIT_EN
    logic [WCNT_W-1:0] wcnt;

    // Wait counter: loaded on accept, counts down while in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            wcnt <= '0;
        else if (accept)                       wcnt <= WAIT_INIT;
        else if (state == ST_WAIT && wcnt != 0) wcnt <= wcnt - 1'b1;
    end
`else
    // Wait states are compiled out; the parameter is intentionally unused.
    logic unused_wait_cfg;
    assign unused_wait_cfg = ^WAIT_INIT;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef DMEM_WAIT_EN
                    state_nxt = (WAIT_INIT != 0) ? ST_WAIT : ST_ACCESS;
`else
                    state_nxt = ST_ACCESS;
`endif
                end
            end
            ST_WAIT: begin
`ifdef DMEM_WAIT_EN
                if (wcnt <= 1) state_nxt = ST_ACCESS;
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_ACCESS: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request capture: MAR follows the strobe in IDLE, which also makes it the
    // effective access address; wdata and direction are frozen at accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mar     <= '0;
            wdata_q <= '0;
            op_rd   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state == ST_IDLE && d_mar) mar <= addr;
            if (accept) begin
                wdata_q <= wdata;
                op_rd   <= rd;
            end
            err_q <= illegal;
            if (state == ST_DONE && op_rd) rdata_q <= mem_dout;
        end
    end

    // Storage; the write fires only in ACCESS, so a reset before ACCESS
    // leaves the array untouched.
    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk  (clk),
        .we   ((state == ST_ACCESS) && !op_rd),
        .addr (mar),
        .din  (wdata_q),
        .dout (mem_dout)
    );

    // In DONE of a read the fresh array output is forwarded; otherwise the
    // last completed read is held.
    assign ready    = (state == ST_DONE);
    assign busy     = (state != ST_IDLE);
    assign rdata_oe = (state == ST_DONE) && op_rd;
    assign rdata    = rdata_oe ? mem_dout : rdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Expected completions are
// queued when a request is driven and checked when ready pulses.
module tb_data_mem_responder;

`ifdef DMEM_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       d_mar = 1'b0;
    logic [7:0] addr = '0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       rdata_oe;
    logic       ready;
    logic       busy;
    logic       err;

    typedef struct {
        bit         is_rd;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [0:255];
    logic [7:0] mar_m = '0;
    logic [7:0] last_rd = '0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    data_mem_responder #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .WAIT_CYCLES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .d_mar    (d_mar),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rdata_oe (rdata_oe),
        .ready    (ready),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every ready pulse must match the oldest queued request.
    always @(negedge clk) begin
        if (reset && ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("rdata_oe", rdata_oe, e.is_rd);
                if (e.is_rd) chk("rdata", rdata, e.data);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    // With junk set, a conflicting write is held on the bus while busy.
    task automatic access(input bit is_rd, input bit dm, input logic [7:0] a,
                          input logic [7:0] wd, input bit junk);
        logic [7:0] ea;
        exp_t       e;
        int         nb;
        bit         done;
        ea = dm ? a : mar_m;
        mar_m = ea;
        d_mar = dm; addr = a; rd = is_rd; wr = !is_rd; wdata = wd;
        e.is_rd = is_rd;
        e.cyc   = cyc + W + 2;
        if (is_rd) begin
            e.data  = model[ea];
            last_rd = model[ea];
        end else begin
            e.data    = wd;
            model[ea] = wd;
        end
        sb.push_back(e);
        @(posedge clk);
        nb = 0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (junk && !ready && busy) begin
                d_mar = 1; addr = a ^ 8'h01; rd = 0; wr = 1; wdata = ~wd;
            end else begin
                d_mar = 0; rd = 0; wr = 0;
            end
            if (!busy) done = 1;
        end
        chk("completed", done, 1);
        chk("busy_cycles", nb, W + 2);
        if (!is_rd) chk("rdata_hold", rdata, last_rd);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_oe", rdata_oe, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        // Write then read back, including both address extremes
        access(0, 1, 8'h10, 8'hA5, 0);
        access(1, 1, 8'h10, 8'h00, 0);
        access(0, 1, 8'hFF, 8'h3C, 0);
        access(1, 1, 8'hFF, 8'h00, 0);
        access(0, 1, 8'h00, 8'h11, 0);
        access(1, 1, 8'h00, 8'h00, 0);
        access(1, 1, 8'h10, 8'h00, 0);

        // rd=wr=1: one-cycle err, no access, stays idle
        access(0, 1, 8'h30, 8'h5A, 0);
        d_mar = 1; addr = 8'h30; rd = 1; wr = 1; wdata = 8'hEE;
        mar_m = 8'h30;
        @(posedge clk);
        #1; d_mar = 0; rd = 0; wr = 0;
        @(negedge clk);
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_clear", err, 0);
        chk("err_idle", busy, 0);
        access(1, 1, 8'h30, 8'h00, 0);

        // Second write while busy is ignored
        access(0, 1, 8'h41, 8'h00, 0);
        access(0, 1, 8'h40, 8'h12, 1);
        access(1, 1, 8'h40, 8'h00, 0);
        access(1, 1, 8'h41, 8'h00, 0);

        // Reset mid-write: outputs clear at once, array keeps old value
        access(0, 1, 8'h20, 8'h66, 0);
        access(1, 1, 8'h20, 8'h00, 0);
        d_mar = 1; addr = 8'h20; rd = 0; wr = 1; wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        reset = 0; d_mar = 0; wr = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_oe", rdata_oe, 0);
        chk("abort_err", err, 0);
        @(negedge clk);
        reset = 1;
        mar_m = 8'h00;
        last_rd = 8'h00;
        @(negedge clk);
        access(1, 1, 8'h20, 8'h00, 0);

        // MAR latched by a bare strobe is used when d_mar=0
        access(0, 1, 8'h05, 8'hC3, 0);
        access(0, 1, 8'h06, 8'h3A, 0);
        d_mar = 1; addr = 8'h05;
        mar_m = 8'h05;
        @(negedge clk);
        d_mar = 0;
        access(1, 0, 8'h06, 8'h00, 0);

        // Randomised write/read pairs
        for (int k = 0; k < 6; k++) begin
            logic [7:0] ra, rv;
            ra = 8'($urandom_range(0, 255));
            rv = 8'($urandom_range(0, 255));
            access(0, 1, ra, rv, 0);
            access(1, 1, ra, 8'h00, 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
